float_add_sub: RTL
==================

FLOAT_ADD_SUB -- requirements
Module: float_add_sub

Interface
REQ-001 SHALL have parameter MANTISSA_SIZE, default 23, stored mantissa bits.
REQ-002 SHALL have parameter EXPONENT_SIZE, default 8, exponent bits with bias 2^(EXPONENT_SIZE-1)-1.
REQ-003 SHALL have parameter TAG_SIZE, default 4, width of the user tag carried alongside each operation.
REQ-004 SHALL have parameter ENABLE_ROUNDING, default 1; 1 = round-to-nearest-even, 0 = truncate toward zero.
REQ-005 SHALL use FLOAT_SIZE = 1+EXPONENT_SIZE+MANTISSA_SIZE, packed {sign, exponent, mantissa}.
REQ-006 Ports:
- clk  in  1  clock; one clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- s_valid  in  1  input operation valid.
- s_ready  out  1  block accepts an operation this cycle.
- s_sub  in  1  0 = a+b, 1 = a-b.
- s_a  in  FLOAT_SIZE  operand a.
- s_b  in  FLOAT_SIZE  operand b.
- s_tag  in  TAG_SIZE  user tag.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_result  out  FLOAT_SIZE  result.
- m_tag  out  TAG_SIZE  tag of the result.
- m_flags  out  4  {invalid, overflow, underflow, inexact}.

Function
REQ-007 SHALL be a 4-stage pipeline: unpack/align, add, leading-one detect, normalize/round/pack; latency 4 cycles from an accepted input to m_valid when unstalled.
REQ-008 SHALL define advance = !m_valid || m_ready; s_ready = advance; all stages shift only when advance = 1 (global stall).
REQ-009 SHALL accept an operation when s_valid && s_ready; each stage carries a valid bit, and bubbles propagate as invalid.
REQ-010 SHALL sustain one operation per cycle while m_ready stays high.
REQ-011 SHALL hold m_result, m_tag, m_flags and m_valid stable while m_valid && !m_ready.
REQ-012 SHALL deliver results in acceptance order with the matching tag; no drop, no duplication.
REQ-013 SHALL implement subtraction by inverting the sign of b before alignment.
REQ-014 SHALL order operands by magnitude as {exponent, mantissa}, not by exponent alone, so that the mantissa difference is never negative.
REQ-015 SHALL align the smaller operand by right shift, and SHALL keep guard, round and sticky bits; for a shift of MANTISSA_SIZE+3 or more, the whole mantissa SHALL fold into sticky.
REQ-016 SHALL fully support subnormal inputs and outputs: hidden bit 0 and effective exponent 1 when the exponent field is 0.
REQ-017 SHALL round per ENABLE_ROUNDING; a mantissa carry-out of rounding SHALL increment the exponent.
REQ-018 SHALL return +0 for an exact zero sum of operands with opposite effective sign, and -0 for (-0)+(-0).
REQ-019 SHALL force the result to infinity with the result sign, and set overflow and inexact, when the exponent reaches all-ones.
REQ-020 SHALL set underflow when the result is subnormal and inexact, and SHALL set inexact whenever any discarded bit is nonzero.
REQ-021 Specials:
- any NaN operand, or inf-inf with effective opposite signs, SHALL give canonical quiet NaN (sign 0, exponent all-ones, mantissa MSB 1, rest 0).
- inf-inf SHALL set invalid; a signalling NaN operand (mantissa MSB 0) SHALL set invalid.
- inf plus a finite operand SHALL return that inf with no flags.

Reset
REQ-022 SHALL, while resetn = 0, asynchronously clear all stage valid bits, m_valid, m_result, m_tag and m_flags to 0; s_ready is then 1.
REQ-023 SHALL discard any operation in flight at reset assertion, and SHALL emit nothing for it after release.

Structure
REQ-024 SHALL place in shared package float_pkg: field-position constants, the FLOAT_SIZE function, the canonical-NaN constant and the flag bit indices.
REQ-025 SHALL instantiate one sub-module, float_lzc: a parametrised combinational leading-one position detector with an all-zero indicator, used in stage 3.

Verification (binary32 defaults)
REQ-026 Basic add and cancellation: 0x3F800000+0x40000000 -> 0x40400000, flags 0; 0x3F800000 sub 0x3F800000 -> 0x00000000, flags 0.
REQ-027 Rounding: 0x3F800000+0x33800000 -> 0x3F800000, inexact (tie to even); 0x3F800000+0x33800001 -> 0x3F800001, inexact.
REQ-028 Specials: 0x7F800000+0xFF800000 -> 0x7FC00000, invalid; 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, overflow|inexact.
REQ-029 Subnormals: 0x00000001+0x00000001 -> 0x00000002, flags 0; 0x00800000 sub 0x00000001 -> 0x007FFFFF, flags 0.
REQ-030 Backpressure: stream 8 tagged ops with m_ready low for cycles 3-9 -> s_ready falls, outputs stay stable, all 8 results arrive in order with correct tags.
REQ-031 Reset mid-stream: assert resetn low with 3 ops in flight -> m_valid is 0 at once, and no stale result appears after release.

Source files
------------

// File: rtl/float_pkg.sv
// Shared constants and helpers for the parametrised floating-point datapath:
// field positions, overall width, canonical quiet NaN and flag bit indices.
package float_pkg;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_COUNT     = 4;

  localparam int MAX_FLOAT_SIZE = 128;

  function automatic int floatSize(input int mantissaSize, input int exponentSize);
    return 1 + exponentSize + mantissaSize;
  endfunction

  function automatic int signPos(input int mantissaSize, input int exponentSize);
    return mantissaSize + exponentSize;
  endfunction

  function automatic int expMsb(input int mantissaSize, input int exponentSize);
    return mantissaSize + exponentSize - 1;
  endfunction

  function automatic int expLsb(input int mantissaSize);
    return mantissaSize;
  endfunction

  // Sign 0, exponent all ones, only the mantissa MSB set.
  function automatic logic [MAX_FLOAT_SIZE-1:0] canonicalNan(input int mantissaSize,
                                                             input int exponentSize);
    logic [MAX_FLOAT_SIZE-1:0] nanValue;
    nanValue = '0;
    for (int i = mantissaSize - 1; i < mantissaSize + exponentSize; i++) nanValue[i] = 1'b1;
    return nanValue;
  endfunction

endpackage

// File: rtl/float_lzc.sv
// Combinational leading-one position detector with an all-zero indicator.
module float_lzc #(
  parameter int WIDTH = 28,
  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] value,
  output logic [POS_W-1:0] onePos,
  output logic             allZero
);

  // Scan upwards so the highest set bit is the last one recorded.
  always_comb begin
    onePos  = '0;
    allZero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) begin
        onePos  = POS_W'(i);
        allZero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/float_add_sub.sv
// Four-stage pipelined floating-point adder/subtractor (align, add, leading-one
// detect, normalise/round/pack) with a global stall and IEEE-style exceptions.
module float_add_sub
  import float_pkg::*;
#(
  parameter int MANTISSA_SIZE   = 23,
  parameter int EXPONENT_SIZE   = 8,
  parameter int TAG_SIZE        = 4,
  parameter int ENABLE_ROUNDING = 1,
  localparam int FLOAT_SIZE     = floatSize(MANTISSA_SIZE, EXPONENT_SIZE)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_sub,
  input  logic [FLOAT_SIZE-1:0] s_a,
  input  logic [FLOAT_SIZE-1:0] s_b,
  input  logic [TAG_SIZE-1:0]   s_tag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FLOAT_SIZE-1:0] m_result,
  output logic [TAG_SIZE-1:0]   m_tag,
  output logic [FLAG_COUNT-1:0] m_flags
);

  localparam int M  = MANTISSA_SIZE;
  localparam int E  = EXPONENT_SIZE;
  localparam int SW = M + 4;  // hidden, mantissa, guard, round, sticky
  localparam int AW = M + 5;  // plus carry-out of the add
  localparam int PW = $clog2(AW);
  localparam int SIGN_POS = signPos(M, E);
  localparam int EXP_MSB  = expMsb(M, E);
  localparam int EXP_LSB  = expLsb(M);
  localparam logic [E-1:0]          EXP_MAX    = '1;
  localparam logic [FLOAT_SIZE-1:0] QNAN       = FLOAT_SIZE'(canonicalNan(M, E));
  localparam logic [31:0]           CARRY_POS  = 32'(M + 4);
  localparam logic [31:0]           HIDDEN_POS = 32'(M + 3);

  logic advance;
  logic signA, signB, nanA, nanB, infA, infB, aBig, special0, invalid0;
  logic [E-1:0] expA, expB, effExpA, effExpB, shiftAmt;
  logic [M-1:0] manA, manB;
  logic [SW-1:0] sigA, sigB, smallSig, alignedSmall;
  logic [2*SW-1:0] shiftedSmall;
  logic [FLOAT_SIZE-1:0] specRes0;

  logic v1, v2, v3;
  logic [TAG_SIZE-1:0] tag1, tag2, tag3;
  logic sign1, sign2, sign3, effSub1, effSub2, effSub3;
  logic special1, special2, special3, invalid1, invalid2, invalid3;
  logic [FLOAT_SIZE-1:0] specRes1, specRes2, specRes3;
  logic [E-1:0] exp1, exp2, exp3;
  logic [SW-1:0] big1, small1;
  logic [AW-1:0] sumNext, sum2, sum3;
  logic [PW-1:0] onePos2, pos3;
  logic allZero2, zero3;

  logic [31:0] pos32, exp32, need, leftShift;
  logic [AW-2:0] norm;
  logic [E:0] expOut, expField;
  logic [E+M:0] packedVal;
  logic [M-1:0] mant;
  logic guard, sticky, tiny, inexact, roundUp, overflow;
  logic [FLOAT_SIZE-1:0] res4;
  logic [FLAG_COUNT-1:0] flags4;

  assign advance = !m_valid || m_ready;
  assign s_ready = advance;

  assign signA = s_a[SIGN_POS];
  assign signB = s_b[SIGN_POS] ^ s_sub;
  assign expA  = s_a[EXP_MSB:EXP_LSB];
  assign expB  = s_b[EXP_MSB:EXP_LSB];
  assign manA  = s_a[M-1:0];
  assign manB  = s_b[M-1:0];

  // Stage 1: classify, pick the larger magnitude, align the smaller with sticky.
  always_comb begin
    nanA    = (expA == EXP_MAX) && (manA != '0);
    nanB    = (expB == EXP_MAX) && (manB != '0);
    infA    = (expA == EXP_MAX) && (manA == '0);
    infB    = (expB == EXP_MAX) && (manB == '0);
    effExpA = (expA == '0) ? E'(1) : expA;
    effExpB = (expB == '0) ? E'(1) : expB;
    sigA    = {expA != '0, manA, 3'b000};
    sigB    = {expB != '0, manB, 3'b000};
    aBig    = {expA, manA} >= {expB, manB};
    shiftAmt = aBig ? effExpA - effExpB : effExpB - effExpA;
    smallSig = aBig ? sigB : sigA;
    shiftedSmall = {smallSig, {SW{1'b0}}} >> shiftAmt;
    if (32'(shiftAmt) >= 32'(SW - 1))
      alignedSmall = {{(SW-1){1'b0}}, |smallSig};
    else
      alignedSmall = shiftedSmall[2*SW-1:SW] | SW'(|shiftedSmall[SW-1:0]);
    special0 = nanA || nanB || infA || infB;
    invalid0 = (nanA && !manA[M-1]) || (nanB && !manB[M-1]) || (infA && infB && (signA != signB));
    if (nanA || nanB || (infA && infB && (signA != signB)))
      specRes0 = QNAN;
    else if (infA)
      specRes0 = {signA, EXP_MAX, {M{1'b0}}};
    else
      specRes0 = {signB, EXP_MAX, {M{1'b0}}};
  end

  assign sumNext = effSub1 ? ({1'b0, big1} - {1'b0, small1}) : ({1'b0, big1} + {1'b0, small1});

  float_lzc #(.WIDTH(AW)) lzc (
    .value  (sum2),
    .onePos (onePos2),
    .allZero(allZero2)
  );

  // Stage 4: normalise (never below the minimum exponent), round, detect overflow.
  always_comb begin
    pos32     = 32'(pos3);
    exp32     = 32'(exp3);
    need      = '0;
    leftShift = '0;
    if (pos32 == CARRY_POS) begin
      norm   = (AW-1)'(sum3 >> 1) | (AW-1)'(sum3[0]);
      expOut = (E+1)'(exp32 + 32'd1);
    end else begin
      need      = HIDDEN_POS - pos32;
      leftShift = (need < exp32 - 32'd1) ? need : exp32 - 32'd1;
      norm      = (AW-1)'(sum3 << leftShift);
      expOut    = (E+1)'(exp32 - leftShift);
    end
    tiny      = !norm[M+3];
    expField  = tiny ? '0 : expOut;
    mant      = norm[M+2:3];
    guard     = norm[2];
    sticky    = norm[1] | norm[0];
    inexact   = guard | sticky;
    roundUp   = (ENABLE_ROUNDING != 0) && guard && (sticky || mant[0]);
    packedVal = {expField, mant} + (E+M+1)'(roundUp);
    overflow  = packedVal[E+M:M] >= {1'b0, EXP_MAX};
    res4   = '0;
    flags4 = '0;
    if (special3) begin
      res4 = specRes3;
      flags4[FLAG_INVALID] = invalid3;
    end else if (zero3) begin
      res4 = {sign3 && !effSub3, {(FLOAT_SIZE-1){1'b0}}};
    end else if (overflow) begin
      res4 = {sign3, EXP_MAX, {M{1'b0}}};
      flags4[FLAG_OVERFLOW] = 1'b1;
      flags4[FLAG_INEXACT]  = 1'b1;
    end else begin
      res4 = {sign3, packedVal[E+M-1:0]};
      flags4[FLAG_INEXACT]   = inexact;
      flags4[FLAG_UNDERFLOW] = tiny && inexact;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      m_valid  <= 1'b0;
      m_result <= '0;
      m_tag    <= '0;
      m_flags  <= '0;
    end else if (advance) begin
      v1       <= s_valid;
      v2       <= v1;
      v3       <= v2;
      m_valid  <= v3;
      m_result <= res4;
      m_tag    <= tag3;
      m_flags  <= flags4;
    end
  end

  // Payload registers need no reset: their valid bits qualify them.
  always_ff @(posedge clk) begin
    if (advance) begin
      tag1     <= s_tag;
      sign1    <= aBig ? signA : signB;
      effSub1  <= signA ^ signB;
      exp1     <= aBig ? effExpA : effExpB;
      big1     <= aBig ? sigA : sigB;
      small1   <= alignedSmall;
      special1 <= special0;
      invalid1 <= invalid0;
      specRes1 <= specRes0;
      tag2     <= tag1;
      sign2    <= sign1;
      effSub2  <= effSub1;
      exp2     <= exp1;
      sum2     <= sumNext;
      special2 <= special1;
      invalid2 <= invalid1;
      specRes2 <= specRes1;
      tag3     <= tag2;
      sign3    <= sign2;
      effSub3  <= effSub2;
      exp3     <= exp2;
      sum3     <= sum2;
      pos3     <= onePos2;
      zero3    <= allZero2;
      special3 <= special2;
      invalid3 <= invalid2;
      specRes3 <= specRes2;
    end
  end

endmodule
